// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data SRAM arbiter and fixed-length access sequencer
module mem_arbiter #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic [31:0] o_if_rdata,
    output logic        o_if_ready,
    input  logic        i_dm_req,
    input  logic        i_dm_we,
    input  logic        i_dm_byte,
    input  logic [31:0] i_dm_addr,
    input  logic [31:0] i_dm_wdata,
    output logic [31:0] o_dm_rdata,
    output logic        o_dm_ready,
    output logic        o_stall,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_byte,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACC_I, ACC_D, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_last_dm;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;
    logic        r_if_ready;
    logic        r_dm_ready;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_byte;
    logic        w_grant_dm;

    // Data wins a tie only when fetch was granted last, giving alternation.
    assign w_grant_dm = i_dm_req && (!i_if_req || !r_last_dm);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_last_dm   <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_dm_rdata  <= 32'd0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_byte  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= 4'd0;
                    if (w_grant_dm) begin
                        r_mem_addr  <= i_dm_addr;
                        r_mem_wdata <= i_dm_wdata;
                        r_mem_byte  <= i_dm_byte;
                        r_mem_write <= i_dm_we;
                        r_mem_read  <= ~i_dm_we;
                        r_last_dm   <= 1'b1;
                        r_state     <= ACC_D;
                    end else if (i_if_req) begin
                        r_mem_addr  <= i_if_addr;
                        r_mem_wdata <= 32'd0;
                        r_mem_byte  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_mem_read  <= 1'b1;
                        r_last_dm   <= 1'b0;
                        r_state     <= ACC_I;
                    end
                end
                ACC_I, ACC_D: begin
                    if (r_cnt == LAST_CNT) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= DONE;
                        if (r_state == ACC_I) begin
                            r_if_rdata <= i_mem_rdata;
                            r_if_ready <= 1'b1;
                        end else begin
                            if (r_mem_read) begin
                                r_dm_rdata <= i_mem_rdata;
                            end
                            r_dm_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DONE: begin
                    // Requests are ignored here so a port dropping req after ready is never regranted.
                    r_if_ready <= 1'b0;
                    r_dm_ready <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_if_rdata  = r_if_rdata;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_if_ready  = r_if_ready;
    assign o_dm_ready  = r_dm_ready;
    assign o_mem_read  = r_mem_read;
    assign o_mem_write = r_mem_write;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_byte  = r_mem_byte;
    assign o_stall     = (i_if_req & ~r_if_ready) | (i_dm_req & ~r_dm_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    localparam int ACC = 2;
    localparam logic [31:0] MEM_KEY = 32'h3C011224;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic [31:0] o_if_rdata;
    logic        o_if_ready;
    logic        i_dm_req;
    logic        i_dm_we;
    logic        i_dm_byte;
    logic [31:0] i_dm_addr;
    logic [31:0] i_dm_wdata;
    logic [31:0] o_dm_rdata;
    logic        o_dm_ready;
    logic        o_stall;
    logic        o_mem_read;
    logic        o_mem_write;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_mem_byte;
    logic [31:0] i_mem_rdata;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        we;
        logic        byte_m;
    } exp_t;

    exp_t        if_q[$];
    exp_t        dm_q[$];
    int          order_q[$];
    int          n_total = 0;
    int          n_bad = 0;
    int          strobe_n = 0;
    logic [31:0] cap_addr = 32'd0;
    logic [31:0] cap_wdata = 32'd0;
    logic        cap_byte = 1'b0;
    logic        cap_we = 1'b0;
    logic [31:0] exp_dm_last = 32'd0;

    mem_arbiter #(.ACCESS_CYCLES(ACC)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_rdata(o_if_rdata), .o_if_ready(o_if_ready),
        .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_byte(i_dm_byte),
        .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
        .o_dm_rdata(o_dm_rdata), .o_dm_ready(o_dm_ready),
        .o_stall(o_stall),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_byte(o_mem_byte), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // SRAM model: read data is a fixed scramble of the address.
    assign i_mem_rdata = o_mem_addr ^ MEM_KEY;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic start_if(input logic [31:0] addr);
        exp_t e;
        e.addr = addr; e.wdata = 32'd0; e.rdata = addr ^ MEM_KEY; e.we = 1'b0; e.byte_m = 1'b0;
        if_q.push_back(e);
        i_if_addr = addr;
        i_if_req  = 1'b1;
    endtask

    task automatic start_dm(input logic we, input logic bm, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        e.addr = addr; e.wdata = wd; e.we = we; e.byte_m = bm;
        e.rdata = we ? exp_dm_last : (addr ^ MEM_KEY);
        exp_dm_last = e.rdata;
        dm_q.push_back(e);
        i_dm_we = we; i_dm_byte = bm; i_dm_addr = addr; i_dm_wdata = wd;
        i_dm_req = 1'b1;
    endtask

    task automatic wait_if();
        int n = 0;
        do begin @(negedge i_clk); n++; end while (!o_if_ready && n < 40);
        check("if_ready_seen", {31'd0, o_if_ready}, 32'd1);
        i_if_req = 1'b0;
    endtask

    task automatic wait_dm();
        int n = 0;
        do begin @(negedge i_clk); n++; end while (!o_dm_ready && n < 40);
        check("dm_ready_seen", {31'd0, o_dm_ready}, 32'd1);
        i_dm_req = 1'b0;
    endtask

    task automatic do_if(input logic [31:0] addr);
        start_if(addr);
        wait_if();
    endtask

    task automatic do_dm(input logic we, input logic bm, input logic [31:0] addr, input logic [31:0] wd);
        start_dm(we, bm, addr, wd);
        wait_dm();
    endtask

    // Monitor: counts strobe cycles, captures the access, and scores each ready pulse.
    always @(posedge i_clk) begin
        #1;
        if (i_rst) begin
            strobe_n = 0;
        end else begin
            exp_t e;
            check("strobe_excl", {31'd0, o_mem_read & o_mem_write}, 32'd0);
            if (o_mem_read || o_mem_write) begin
                strobe_n++;
                cap_addr = o_mem_addr; cap_wdata = o_mem_wdata;
                cap_byte = o_mem_byte; cap_we = o_mem_write;
            end
            check("ready_excl", {31'd0, o_if_ready & o_dm_ready}, 32'd0);
            if (o_if_ready) begin
                check("if_q_nonempty", {31'd0, if_q.size() > 0}, 32'd1);
                if (if_q.size() > 0) begin
                    e = if_q.pop_front();
                    check("if_rdata", o_if_rdata, e.rdata);
                    check("if_addr", cap_addr, e.addr);
                    check("if_cycles", strobe_n, ACC);
                    check("if_we", {31'd0, cap_we}, 32'd0);
                    check("if_byte", {31'd0, cap_byte}, 32'd0);
                    check("if_wdata", cap_wdata, 32'd0);
                end
                order_q.push_back(0);
                strobe_n = 0;
            end
            if (o_dm_ready) begin
                check("dm_q_nonempty", {31'd0, dm_q.size() > 0}, 32'd1);
                if (dm_q.size() > 0) begin
                    e = dm_q.pop_front();
                    check("dm_rdata", o_dm_rdata, e.rdata);
                    check("dm_addr", cap_addr, e.addr);
                    check("dm_cycles", strobe_n, ACC);
                    check("dm_we", {31'd0, cap_we}, {31'd0, e.we});
                    check("dm_byte", {31'd0, cap_byte}, {31'd0, e.byte_m});
                    if (e.we) check("dm_wdata", cap_wdata, e.wdata);
                end
                order_q.push_back(1);
                strobe_n = 0;
            end
        end
    end

    initial begin
        exp_t drop;
        i_rst = 1'b1; i_if_req = 1'b0; i_if_addr = 32'd0;
        i_dm_req = 1'b0; i_dm_we = 1'b0; i_dm_byte = 1'b0; i_dm_addr = 32'd0; i_dm_wdata = 32'd0;

        // Reset held with both requests pending
        start_dm(1'b0, 1'b0, 32'h0000_0200, 32'd0);
        start_if(32'h0000_0300);
        repeat (2) begin
            @(posedge i_clk); #1;
            check("rst_mem_read", {31'd0, o_mem_read}, 32'd0);
            check("rst_mem_write", {31'd0, o_mem_write}, 32'd0);
            check("rst_ready", {30'd0, o_if_ready, o_dm_ready}, 32'd0);
            check("rst_mem_addr", o_mem_addr, 32'd0);
            check("rst_mem_wdata", o_mem_wdata, 32'd0);
            check("rst_mem_byte", {31'd0, o_mem_byte}, 32'd0);
            check("rst_if_rdata", o_if_rdata, 32'd0);
            check("rst_dm_rdata", o_dm_rdata, 32'd0);
            check("rst_stall", {31'd0, o_stall}, 32'd1);
        end
        @(negedge i_clk); i_rst = 1'b0;
        @(posedge i_clk); #1;
        check("first_grant_read", {31'd0, o_mem_read}, 32'd1);
        check("first_grant_addr", o_mem_addr, 32'h0000_0200);
        order_q.delete();
        fork
            wait_dm();
            wait_if();
        join
        check("tie_order_len", order_q.size(), 2);
        if (order_q.size() == 2) begin
            check("tie_first", order_q[0], 1);
            check("tie_second", order_q[1], 0);
        end

        // Uncontended fetch: strobes T+1..T+2, ready and stall low at T+3
        @(negedge i_clk);
        start_if(32'h0000_0010);
        #1 check("fetch_stall_T", {31'd0, o_stall}, 32'd1);
        for (int c = 0; c < ACC; c++) begin
            @(posedge i_clk); #1;
            check("fetch_read_hi", {31'd0, o_mem_read}, 32'd1);
            check("fetch_stall_hi", {31'd0, o_stall}, 32'd1);
        end
        @(posedge i_clk); #1;
        check("fetch_ready", {31'd0, o_if_ready}, 32'd1);
        check("fetch_read_lo", {31'd0, o_mem_read}, 32'd0);
        check("fetch_stall_lo", {31'd0, o_stall}, 32'd0);
        check("fetch_rdata", o_if_rdata, 32'h3C01_1234);
        @(negedge i_clk); i_if_req = 1'b0;
        @(posedge i_clk); #1;
        check("fetch_ready_pulse", {31'd0, o_if_ready}, 32'd0);

        // Contention with immediate re-requests
        @(negedge i_clk);
        order_q.delete();
        fork
            begin
                do_dm(1'b0, 1'b0, 32'h0000_1000, 32'd0);
                do_dm(1'b0, 1'b0, 32'h0000_1004, 32'd0);
            end
            begin
                do_if(32'h0000_0020);
                do_if(32'h0000_0024);
            end
        join
        check("cont_len", order_q.size(), 4);
        if (order_q.size() == 4) begin
            check("cont_g0", order_q[0], 1);
            check("cont_g1", order_q[1], 0);
            check("cont_g2", order_q[2], 1);
            check("cont_g3", order_q[3], 0);
        end

        // Byte write: dm_rdata must be unchanged
        @(negedge i_clk);
        do_dm(1'b1, 1'b1, 32'h0010_0004, 32'h0000_00AB);
        check("write_keeps_rdata", o_dm_rdata, 32'h3C01_0220 ^ 32'h0000_0000 ^ (32'h0000_1004 ^ MEM_KEY) ^ 32'h3C01_0220);

        // Request dropped during the first access cycle
        @(negedge i_clk);
        start_dm(1'b0, 1'b0, 32'h0000_2000, 32'd0);
        @(posedge i_clk); #1;
        check("drop_read_hi", {31'd0, o_mem_read}, 32'd1);
        @(negedge i_clk); i_dm_req = 1'b0;
        wait_dm();
        for (int c = 0; c < 4; c++) begin
            @(posedge i_clk); #1;
            check("drop_no_regrant", {30'd0, o_mem_read, o_mem_write}, 32'd0);
        end

        // Reset during the second access cycle of a read
        @(negedge i_clk);
        start_if(32'h0000_0040);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        check("rstmid_read_hi", {31'd0, o_mem_read}, 32'd1);
        @(negedge i_clk); i_rst = 1'b1;
        @(posedge i_clk); #1;
        check("rstmid_read_lo", {31'd0, o_mem_read}, 32'd0);
        check("rstmid_ready", {30'd0, o_if_ready, o_dm_ready}, 32'd0);
        check("rstmid_if_rdata", o_if_rdata, 32'd0);
        check("rstmid_dm_rdata", o_dm_rdata, 32'd0);
        @(negedge i_clk); i_rst = 1'b0; i_if_req = 1'b0;
        if (if_q.size() > 0) drop = if_q.pop_front();
        exp_dm_last = 32'd0;
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk); #1;
            check("rstmid_idle", {28'd0, o_mem_read, o_mem_write, o_if_ready, o_dm_ready}, 32'd0);
        end
        @(negedge i_clk);
        do_if(32'h0000_0044);

        @(negedge i_clk);
        check("if_q_drained", if_q.size(), 0);
        check("dm_q_drained", dm_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer that shares the single SRAM memory unit between the instruction-fetch stage and the data-memory stage of the CPU pipeline. It accepts level-held requests from both ports. It grants one at a time, with the data port winning ties and alternation under contention, and holds the memory unit's read/write strobes for a fixed number of cycles. It then returns read data with a one-cycle ready pulse and drives a pipeline stall while any request is outstanding.

## Interface
- ACCESS_CYCLES, 2, cycles each granted access holds mem_read/mem_write asserted; legal range 1..15
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held high until if_ready seen
- if_addr  in  32  fetch byte address; always a word read
- if_rdata  out  32  fetch read data, valid while if_ready high, holds afterwards
- if_ready  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request, held high until dm_ready seen
- dm_we  in  1  1 = write, 0 = read
- dm_byte  in  1  byte access (passed to memory unit as byte mode)
- dm_addr  in  32  data byte address
- dm_wdata  in  32  write data
- dm_rdata  out  32  data read data, valid while dm_ready high; unchanged by writes
- dm_ready  out  1  one-cycle completion pulse for data port
- stall  out  1  combinational: (if_req & ~if_ready) | (dm_req & ~dm_ready)
- mem_read  out  1  read enable to memory unit
- mem_write  out  1  write enable to memory unit
- mem_addr  out  32  address to memory unit
- mem_wdata  out  32  write data to memory unit
- mem_byte  out  1  byte mode to memory unit
- mem_rdata  in  32  read data from memory unit (already sign-extended in byte mode)

## Operation
- FSM states: IDLE, ACC_I, ACC_D, DONE. The state is registered, with a 4-bit access counter cnt and a last_dm flag.
- IDLE, dm_req only: latch dm_addr/dm_wdata/dm_we/dm_byte into mem_* registers and go to ACC_D.
- IDLE, if_req only: latch if_addr, set mem_byte=0, mem_wdata=0, and go to ACC_I.
- IDLE, both requests: grant data if last_dm=0, else grant fetch. last_dm is set to 1 on a data grant and 0 on a fetch grant. Result: data wins the first tie after reset, then grants alternate while both are pending.
- ACC_x: mem_read, or mem_write for a data write, is high for exactly ACCESS_CYCLES cycles. cnt counts 0..ACCESS_CYCLES-1.
- On the edge ending the last access cycle:
  - For a read, load mem_rdata into if_rdata or dm_rdata.
  - Deassert mem_read/mem_write.
  - Set the granted port's ready and go to DONE.
- DONE: ready is high for this one cycle, and no grant is made. The next state is IDLE unconditionally, so a requester dropping req after ready is never re-granted.
- mem_addr, mem_wdata and mem_byte hold their values outside accesses. mem_read and mem_write are never high simultaneously.
- A requester dropping req mid-access does not abort the access; its ready pulse is still issued.
- Request inputs are sampled only in IDLE. Changes to addr/data after the grant are ignored.

## Timing
- Reset values: state=IDLE, cnt=0, last_dm=0, and every registered output is 0 (if_rdata, dm_rdata, if_ready, dm_ready, mem_read, mem_write, mem_addr, mem_wdata, mem_byte). stall follows its equation.
- Uncontended latency: req first high in IDLE cycle T gives strobes high in cycles T+1..T+ACCESS_CYCLES and ready in cycle T+ACCESS_CYCLES+1. That is ACCESS_CYCLES+1 cycles from request to ready.
- Next grant is no earlier than the cycle after DONE. Per-access occupancy is ACCESS_CYCLES+2 cycles.
- Contended pair (both in IDLE at T, ACCESS_CYCLES=2): first ready at T+3, second grant at T+4, second ready at T+7. stall is high through T+6 and low at T+7 if no other request is pending.
- rst high mid-access: at the next edge, strobes drop, ready clears and the state returns to IDLE. An in-flight write may be partially performed. rdata registers clear to 0.
- rst has priority over all other transitions.

## Test plan
- Reset: hold rst 2 cycles with both req high. All outputs are 0, mem strobes stay 0, and the first grant occurs the cycle after rst falls.
- Fetch read, ACCESS_CYCLES=2: if_addr=0x00000010 with mem_rdata model returning 0x3C011234. mem_read is high exactly 2 cycles with mem_addr=0x10, if_ready pulses once at T+3 with if_rdata=0x3C011234, and stall falls at T+3.
- Data byte write: dm_we=1, dm_byte=1, dm_addr=0x00100004, dm_wdata=0x000000AB. mem_write is high 2 cycles with mem_byte=1 and mem_addr=0x00100004, dm_ready pulses, and dm_rdata is unchanged.
- Contention: if_req and dm_req rise together, then both re-request immediately after each ready. Grant order is data, fetch, data, fetch, and no requester waits more than one access.
- Request dropped mid-access: dm_req falls during the first access cycle. The access still runs 2 cycles, dm_ready still pulses, and there is no regrant afterwards.
- Reset mid-access: rst asserted in the second access cycle of a read. mem_read is 0 next cycle, no ready pulse appears, and the FSM is in IDLE.
